// File: rtl/wctl_barrier_unit_pkg.sv
// Shared types and sizing for the warp-control barrier unit.
// Widths follow the global warp/barrier count defines so every consumer agrees.
`ifndef WCTL_NUM_WARPS
`define WCTL_NUM_WARPS 4
`endif
`ifndef WCTL_NUM_BARRIERS
`define WCTL_NUM_BARRIERS 4
`endif

package wctl_barrier_unit_pkg;

    localparam int NUM_WARPS    = `WCTL_NUM_WARPS;
    localparam int NUM_BARRIERS = `WCTL_NUM_BARRIERS;
    localparam int NW_BITS      = $clog2(NUM_WARPS);
    localparam int NB_BITS      = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;

    typedef struct packed {
        logic [NW_BITS-1:0] wid;
        logic [NB_BITS-1:0] bar_id;
        logic [NW_BITS-1:0] size_m1;
    } bar_req_t;

    typedef struct packed {
        logic                 busy;
        logic [NW_BITS-1:0]   size;
        logic [NW_BITS-1:0]   count;
        logic [NUM_WARPS-1:0] mask;
    } slot_state_t;

    function automatic logic [NW_BITS:0] popcount(input logic [NUM_WARPS-1:0] v);
        logic [NW_BITS:0] n;
        n = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            n = n + {{NW_BITS{1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/wctl_barrier_slot.sv
// One barrier slot: arrival table entry with deactivation pruning and
// a combinational release strobe for the cycle the closing arrival is accepted.
module wctl_barrier_slot
    import wctl_barrier_unit_pkg::*;
#(
    parameter int SLOT_ID = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 accept,
    input  bar_req_t             req,
    input  logic [NUM_WARPS-1:0] warp_active,
    output logic [NUM_WARPS-1:0] stall_mask,
    output logic                 rel_strobe,
    output logic [NUM_WARPS-1:0] rel_mask,
    output logic                 err
);

    slot_state_t          st_q, st_d;
    logic                 hit;
    logic                 live_busy;
    logic [NUM_WARPS-1:0] live_mask;
    logic [NUM_WARPS-1:0] bit_w;
    logic [NW_BITS-1:0]   live_count;

    always_comb begin
        hit        = accept && (req.bar_id == NB_BITS'(SLOT_ID));
        bit_w      = {{(NUM_WARPS-1){1'b0}}, 1'b1} << req.wid;
        // Deactivated warps leave first; the arrival then sees the reduced table.
        live_mask  = st_q.mask & warp_active;
        live_busy  = st_q.busy && (live_mask != '0);
        live_count = st_q.count - NW_BITS'(popcount(st_q.mask & ~warp_active));

        st_d       = '0;
        rel_strobe = 1'b0;
        rel_mask   = '0;
        err        = 1'b0;
        if (live_busy) begin
            st_d.busy  = 1'b1;
            st_d.size  = st_q.size;
            st_d.count = live_count;
            st_d.mask  = live_mask;
        end

        if (hit) begin
            if (!warp_active[req.wid]) begin
                err = 1'b1;
            end else if (!live_busy) begin
                if (req.size_m1 == '0) begin
                    rel_strobe = 1'b1;
                    rel_mask   = bit_w;
                end else begin
                    st_d.busy  = 1'b1;
                    st_d.size  = req.size_m1;
                    st_d.count = '0;
                    st_d.mask  = bit_w;
                end
            end else if (live_mask[req.wid]) begin
                err = 1'b1;
            end else begin
                err = (req.size_m1 != st_q.size);
                if (live_count + NW_BITS'(1) == st_q.size) begin
                    rel_strobe = 1'b1;
                    rel_mask   = live_mask | bit_w;
                    st_d       = '0;
                end else begin
                    st_d.mask  = live_mask | bit_w;
                    st_d.count = live_count + NW_BITS'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q <= '0;
        end else begin
            st_q <= st_d;
        end
    end

    assign stall_mask = st_q.mask;

endmodule

// File: rtl/wctl_barrier_unit.sv
// Barrier arrival consumer: routes requests to slots, merges stall masks
// and registers the single-cycle release pulse back to the warp scheduler.
module wctl_barrier_unit
    import wctl_barrier_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [NW_BITS-1:0]   req_wid,
    input  logic [NB_BITS-1:0]   req_bar_id,
    input  logic [NW_BITS-1:0]   req_size_m1,
    input  logic [NUM_WARPS-1:0] warp_active,
    output logic [NUM_WARPS-1:0] barrier_stalls,
    output logic                 release_valid,
    output logic [NB_BITS-1:0]   release_id,
    output logic [NUM_WARPS-1:0] release_mask,
    output logic                 error
);

    logic                 req_ready_q, req_ready_d;
    logic                 release_valid_q, release_valid_d;
    logic [NB_BITS-1:0]   release_id_q, release_id_d;
    logic [NUM_WARPS-1:0] release_mask_q, release_mask_d;
    logic                 error_q, error_d;

    logic                 accept;
    bar_req_t             req;
    logic [NUM_BARRIERS-1:0] slot_rel;
    logic [NUM_BARRIERS-1:0] slot_err;
    logic [NUM_WARPS-1:0]    slot_stall    [NUM_BARRIERS];
    logic [NUM_WARPS-1:0]    slot_rel_mask [NUM_BARRIERS];

    assign accept = req_valid && req_ready_q;
    assign req    = '{wid: req_wid, bar_id: req_bar_id, size_m1: req_size_m1};

    for (genvar g = 0; g < NUM_BARRIERS; g++) begin : g_slot
        wctl_barrier_slot #(.SLOT_ID(g)) u_slot (
            .clk         (clk),
            .reset_n     (reset_n),
            .accept      (accept),
            .req         (req),
            .warp_active (warp_active),
            .stall_mask  (slot_stall[g]),
            .rel_strobe  (slot_rel[g]),
            .rel_mask    (slot_rel_mask[g]),
            .err         (slot_err[g])
        );
    end

    always_comb begin
        req_ready_d     = 1'b1;
        release_valid_d = 1'b0;
        release_id_d    = '0;
        release_mask_d  = '0;
        error_d         = error_q | (|slot_err);
        barrier_stalls  = '0;
        // Only one request is accepted per cycle, so at most one slot strobes.
        for (int i = 0; i < NUM_BARRIERS; i++) begin
            barrier_stalls = barrier_stalls | slot_stall[i];
            if (slot_rel[i]) begin
                release_valid_d = 1'b1;
                release_id_d    = NB_BITS'(i);
                release_mask_d  = slot_rel_mask[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_ready_q     <= 1'b0;
            release_valid_q <= 1'b0;
            release_id_q    <= '0;
            release_mask_q  <= '0;
            error_q         <= 1'b0;
        end else begin
            req_ready_q     <= req_ready_d;
            release_valid_q <= release_valid_d;
            release_id_q    <= release_id_d;
            release_mask_q  <= release_mask_d;
            error_q         <= error_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign release_valid = release_valid_q;
    assign release_id    = release_id_q;
    assign release_mask  = release_mask_q;
    assign error         = error_q;

endmodule

// File: tb/tb_wctl_barrier_unit.sv
// Bench for wctl_barrier_unit: directed vector table, hand-written corner
// sequences and a randomized run against a set-based barrier model.
module tb_wctl_barrier_unit;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_wid;
    logic [1:0] req_bar_id;
    logic [1:0] req_size_m1;
    logic [3:0] warp_active;
    logic [3:0] barrier_stalls;
    logic       release_valid;
    logic [1:0] release_id;
    logic [3:0] release_mask;
    logic       error;

    int checks   = 0;
    int failures = 0;

    wctl_barrier_unit dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_wid        (req_wid),
        .req_bar_id     (req_bar_id),
        .req_size_m1    (req_size_m1),
        .warp_active    (warp_active),
        .barrier_stalls (barrier_stalls),
        .release_valid  (release_valid),
        .release_id     (release_id),
        .release_mask   (release_mask),
        .error          (error)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: each barrier is a set of arrived warps plus the
    // number of participants it waits for (0 = idle).
    logic [3:0] m_mask [4];
    int         m_need [4];
    logic       m_ready, m_err, m_rv;
    int         m_rid;
    logic [3:0] m_rmask;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_mask[i] = 4'b0;
            m_need[i] = 0;
        end
        m_ready = 1'b0;
        m_err   = 1'b0;
        m_rv    = 1'b0;
        m_rid   = 0;
        m_rmask = 4'b0;
    endtask

    function automatic logic [3:0] m_stalls();
        logic [3:0] s;
        s = 4'b0;
        for (int i = 0; i < 4; i++) s = s | m_mask[i];
        return s;
    endfunction

    task automatic model_step(input logic v, input int w, input int b, input int s,
                              input logic [3:0] a);
        logic [3:0] bitw;
        bitw    = 4'b0001 << w;
        m_rv    = 1'b0;
        m_rid   = 0;
        m_rmask = 4'b0;
        for (int i = 0; i < 4; i++) begin
            m_mask[i] = m_mask[i] & a;
            if (m_mask[i] == 4'b0) m_need[i] = 0;
        end
        if (v && m_ready) begin
            if (!a[w]) begin
                m_err = 1'b1;
            end else if (m_need[b] == 0) begin
                if (s == 0) begin
                    m_rv = 1'b1; m_rid = b; m_rmask = bitw;
                end else begin
                    m_need[b] = s + 1;
                    m_mask[b] = bitw;
                end
            end else if ((m_mask[b] & bitw) != 4'b0) begin
                m_err = 1'b1;
            end else begin
                if (s + 1 != m_need[b]) m_err = 1'b1;
                m_mask[b] = m_mask[b] | bitw;
                if ($countones(m_mask[b]) == m_need[b]) begin
                    m_rv = 1'b1; m_rid = b; m_rmask = m_mask[b];
                    m_mask[b] = 4'b0;
                    m_need[b] = 0;
                end
            end
        end
        m_ready = 1'b1;
    endtask

    task automatic chk(input string nm, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic step(input logic v, input int w, input int b, input int s,
                        input logic [3:0] a);
        req_valid   = v;
        req_wid     = 2'(w);
        req_bar_id  = 2'(b);
        req_size_m1 = 2'(s);
        warp_active = a;
        @(posedge clk);
        #1;
        model_step(v, w, b, s, a);
    endtask

    task automatic compare_model(input string tag);
        chk({tag, "_stalls"}, barrier_stalls, m_stalls());
        chk({tag, "_rel_valid"}, release_valid, m_rv);
        if (m_rv) begin
            chk({tag, "_rel_id"}, release_id, m_rid);
            chk({tag, "_rel_mask"}, release_mask, m_rmask);
        end
        chk({tag, "_error"}, error, m_err);
        chk({tag, "_ready"}, req_ready, m_ready);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        model_reset();
        step(1'b0, 0, 0, 0, 4'hF);
        compare_model("post_reset");
    endtask

    typedef struct {
        logic       v;
        int         w;
        int         b;
        int         s;
        logic [3:0] stalls;
        logic       rv;
        int         rid;
        logic [3:0] rmask;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, int w, int b, int s, logic [3:0] st,
                                logic rv, int rid, logic [3:0] rm, logic e);
        vec_t r;
        r.v = v; r.w = w; r.b = b; r.s = s; r.stalls = st;
        r.rv = rv; r.rid = rid; r.rmask = rm; r.err = e;
        return r;
    endfunction

    int rs [4];

    initial begin
        // Four-warp barrier on bar0
        tbl.push_back(mk(1, 0, 0, 3, 4'b0001, 0, 0, 4'b0000, 0));
        tbl.push_back(mk(1, 1, 0, 3, 4'b0011, 0, 0, 4'b0000, 0));
        tbl.push_back(mk(1, 2, 0, 3, 4'b0111, 0, 0, 4'b0000, 0));
        tbl.push_back(mk(1, 3, 0, 3, 4'b0000, 1, 0, 4'b1111, 0));
        // Single-warp barrier
        tbl.push_back(mk(1, 2, 1, 0, 4'b0000, 1, 1, 4'b0100, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 0));
        // Interleaved bars
        tbl.push_back(mk(1, 0, 0, 1, 4'b0001, 0, 0, 4'b0000, 0));
        tbl.push_back(mk(1, 2, 1, 1, 4'b0101, 0, 0, 4'b0000, 0));
        tbl.push_back(mk(1, 1, 0, 1, 4'b0100, 1, 0, 4'b0011, 0));
        tbl.push_back(mk(1, 3, 1, 1, 4'b0000, 1, 1, 4'b1100, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 0, 0, 4'b0000, 0));
        // Duplicate arrival
        tbl.push_back(mk(1, 1, 0, 2, 4'b0010, 0, 0, 4'b0000, 0));
        tbl.push_back(mk(1, 1, 0, 2, 4'b0010, 0, 0, 4'b0000, 1));
        tbl.push_back(mk(1, 0, 0, 2, 4'b0011, 0, 0, 4'b0000, 1));
        tbl.push_back(mk(1, 2, 0, 2, 4'b0000, 1, 0, 4'b0111, 1));

        reset_n     = 1'b0;
        req_valid   = 1'b0;
        req_wid     = 2'd0;
        req_bar_id  = 2'd0;
        req_size_m1 = 2'd0;
        warp_active = 4'hF;
        model_reset();
        #12;
        chk("rst_ready", req_ready, 0);
        chk("rst_stalls", barrier_stalls, 0);
        chk("rst_rel_valid", release_valid, 0);
        chk("rst_rel_id", release_id, 0);
        chk("rst_rel_mask", release_mask, 0);
        chk("rst_error", error, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("ready_before_edge", req_ready, 0);
        step(1'b0, 0, 0, 0, 4'hF);
        chk("ready_after_edge", req_ready, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].w, tbl[i].b, tbl[i].s, 4'hF);
            chk($sformatf("tbl%0d_stalls", i), barrier_stalls, tbl[i].stalls);
            chk($sformatf("tbl%0d_rel_valid", i), release_valid, tbl[i].rv);
            if (tbl[i].rv) begin
                chk($sformatf("tbl%0d_rel_id", i), release_id, tbl[i].rid);
                chk($sformatf("tbl%0d_rel_mask", i), release_mask, tbl[i].rmask);
            end
            chk($sformatf("tbl%0d_error", i), error, tbl[i].err);
        end
        step(1'b0, 0, 0, 0, 4'hF);
        chk("err_sticky", error, 1);

        // Deactivation of a waiting warp
        do_reset();
        step(1'b1, 0, 0, 2, 4'hF);
        step(1'b1, 1, 0, 2, 4'hF);
        chk("deact_pre_stalls", barrier_stalls, 4'b0011);
        step(1'b0, 0, 0, 0, 4'b1101);
        chk("deact_stalls", barrier_stalls, 4'b0001);
        chk("deact_no_rel", release_valid, 0);
        step(1'b0, 0, 0, 0, 4'hF);
        compare_model("deact_idle");
        step(1'b1, 1, 0, 2, 4'hF);
        chk("deact_rearrive", barrier_stalls, 4'b0011);
        step(1'b1, 2, 0, 2, 4'hF);
        chk("deact_rel_valid", release_valid, 1);
        chk("deact_rel_mask", release_mask, 4'b0111);
        chk("deact_rel_id", release_id, 0);
        chk("deact_err", error, 0);

        // Sole waiter deactivated: slot empties silently, next arrival starts fresh
        step(1'b1, 3, 2, 1, 4'hF);
        step(1'b0, 0, 0, 0, 4'b0111);
        chk("empty_stalls", barrier_stalls, 4'b0000);
        chk("empty_no_rel", release_valid, 0);
        step(1'b1, 3, 2, 1, 4'hF);
        chk("empty_fresh", barrier_stalls, 4'b1000);
        // Arrival from an inactive warp is dropped with error
        step(1'b1, 0, 2, 1, 4'b1110);
        chk("inactive_err", error, 1);
        chk("inactive_stalls", barrier_stalls, 4'b1000);
        chk("inactive_no_rel", release_valid, 0);

        // Size mismatch: latched size wins, arrival still counts
        do_reset();
        step(1'b1, 0, 3, 1, 4'hF);
        step(1'b1, 1, 3, 3, 4'hF);
        chk("size_mm_rel", release_valid, 1);
        chk("size_mm_mask", release_mask, 4'b0011);
        chk("size_mm_id", release_id, 3);
        chk("size_mm_err", error, 1);

        // Reset mid-barrier
        do_reset();
        step(1'b1, 0, 0, 2, 4'hF);
        step(1'b1, 1, 0, 2, 4'hF);
        chk("mid_pre_stalls", barrier_stalls, 4'b0011);
        req_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_stalls", barrier_stalls, 0);
        chk("mid_rst_rel", release_valid, 0);
        chk("mid_rst_ready", req_ready, 0);
        #2;
        reset_n = 1'b1;
        #1;
        chk("mid_rst_ready_hold", req_ready, 0);
        model_reset();
        step(1'b0, 0, 0, 0, 4'hF);
        chk("mid_rst_ready_up", req_ready, 1);
        chk("mid_rst_no_rel", release_valid, 0);
        chk("mid_rst_stalls_after", barrier_stalls, 0);

        // Randomized run against the model
        for (int i = 0; i < 4; i++) rs[i] = $urandom_range(0, 3);
        for (int n = 0; n < 400; n++) begin
            logic       v;
            int         w, b, s, k;
            logic [3:0] a;
            if (n % 50 == 0) do_reset();
            v = ($urandom_range(0, 9) < 7);
            w = $urandom_range(0, 3);
            b = $urandom_range(0, 3);
            s = rs[b];
            if ($urandom_range(0, 19) == 0) s = $urandom_range(0, 3);
            a = 4'hF;
            if ($urandom_range(0, 9) == 0) begin
                k = $urandom_range(0, 3);
                a[k] = 1'b0;
            end
            step(v, w, b, s, a);
            compare_model("rnd");
            if (m_rv) rs[m_rid] = $urandom_range(0, 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
